regfile_cfg_bank: RTL
=====================

REGFILE_CFG_BANK -- requirements
Module: regfile_cfg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and bus data width.
REQ-002 SHALL have parameter ADDR_W, default 14, address width.
REQ-003 SHALL have parameter N_RW, default 11, number of read/write config registers.
REQ-004 SHALL have parameter RW_BASE, default 'h1, address of config register 0.
REQ-005 SHALL have parameter N_STAT, default 2, number of read-only status words.
REQ-006 SHALL have parameter STAT_BASE, default 'h40, address of status word 0.
REQ-007 SHALL have parameter EVT_ADDR, default 'h42, sticky event register; the IRQ mask register is at EVT_ADDR+1.
REQ-008 SHALL have parameter CMD_ADDR, default 'h80, write-only command register.
REQ-009 SHALL have parameter N_CMD, default 10, number of command bits (at most DATA_W).
REQ-010 SHALL have ports, in this order: clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-011 SHALL have wr_en in 1, write strobe; rd_en in 1, read strobe; addr in ADDR_W, register address; write_data in DATA_W, write data.
REQ-012 SHALL have read_data out DATA_W, registered read data; rd_valid out 1, read data valid for one cycle.
REQ-013 SHALL have addr_err out 1, one-cycle pulse on access to an unmapped address.
REQ-014 SHALL have cfg_q out N_RW*DATA_W, config registers flattened; register i occupies bits [i*DATA_W +: DATA_W].
REQ-015 SHALL have status_in in N_STAT*DATA_W, status words; event_in in DATA_W, event set pulses; irq out 1, interrupt; cmd_pulse out N_CMD, command pulses.

Function
REQ-016 A write with wr_en=1 and addr=RW_BASE+i (i<N_RW) SHALL load write_data into config register i at the next clk edge; cfg_q SHALL reflect the new value from that edge.
REQ-017 A read with rd_en=1 SHALL set read_data to the addressed value and rd_valid=1 at the next edge; otherwise rd_valid=0 and read_data SHALL hold its value.
REQ-018 Simultaneous wr_en and rd_en to the same address SHALL return the pre-write value.
REQ-019 A status read SHALL return status_in word (addr-STAT_BASE) as sampled at the rd_en cycle.
REQ-020 Event bit k SHALL set when event_in[k]=1 and clear when written 1 at EVT_ADDR (W1C); if set and clear coincide, set SHALL win.
REQ-021 The mask register SHALL be RW; irq SHALL be registered as OR(evt & mask), i.e. one cycle after evt or mask changes.
REQ-022 A write to CMD_ADDR SHALL drive cmd_pulse=write_data[N_CMD-1:0] for exactly one cycle; back-to-back writes SHALL yield back-to-back pulses; a read of CMD_ADDR SHALL return 0.
REQ-023 A write to a read-only address (status) SHALL be ignored without error.
REQ-024 A read or write to an unmapped address SHALL assert addr_err for one cycle (once, even if both strobes are set); the write SHALL be dropped and the read SHALL return 0 with rd_valid=1.
REQ-025 Address comparison SHALL use all ADDR_W bits; no aliasing.

Reset
REQ-026 While rst=1: config, event and mask registers SHALL be 0; read_data=0, rd_valid=0, addr_err=0, irq=0, cmd_pulse=0.
REQ-027 Reset asserted mid-pulse SHALL clear cmd_pulse immediately (asynchronously); a write in the first edge after deassertion SHALL take effect normally.

Structure
REQ-028 A shared package regfile_pkg SHALL hold the default address constants, DATA_W/ADDR_W defaults, and an access-type enum (ACC_RW, ACC_RO, ACC_W1C, ACC_WOC, ACC_NONE).
REQ-029 A single sub-module regfile_addr_decode SHALL map addr to an access type plus an index; all storage SHALL remain in regfile_cfg_bank.

Verification
REQ-030 Write 'hABCD to 'h3, then read 'h3 -> cfg_q word 2='hABCD; read_data='hABCD with rd_valid=1 exactly one cycle after rd_en.
REQ-031 Hold status_in word1='h1234 and read 'h41 -> 'h1234; write 'hFFFF to 'h41 -> no change and addr_err=0.
REQ-032 Pulse event_in='h0005 with mask='h0004 -> evt='h0005, irq=1 next cycle; write 'h0004 to EVT_ADDR while event_in[2]=1 -> bit 2 stays set; repeat with event_in=0 -> evt='h0001, irq=0.
REQ-033 Write 'h0201 then 'h0001 to 'h80 on consecutive cycles -> cmd_pulse='h201 then 'h001, then 0; read 'h80 -> 0.
REQ-034 Read and write 'h3FFF in the same cycle -> single addr_err pulse, read_data=0, no config change.
REQ-035 Assert rst during a cmd_pulse and with config registers nonzero -> all outputs 0 immediately; a write on the first cycle after release is captured.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the configuration register bank: default
//   parameter values, the default register map and the access-type enum
//   that the address decoder produces.
//   No ports (package).
package regfile_pkg;

  localparam int          DEF_DATA_W    = 16;
  localparam int          DEF_ADDR_W    = 14;
  localparam int          DEF_N_RW      = 11;
  localparam int unsigned DEF_RW_BASE   = 'h1;
  localparam int          DEF_N_STAT    = 2;
  localparam int unsigned DEF_STAT_BASE = 'h40;
  localparam int unsigned DEF_EVT_ADDR  = 'h42;
  localparam int unsigned DEF_CMD_ADDR  = 'h80;
  localparam int          DEF_N_CMD     = 10;

  // Access behaviour of a decoded address.
  typedef enum logic [2:0] {
    ACC_RW,    // config register or IRQ mask
    ACC_RO,    // status word
    ACC_W1C,   // sticky event register
    ACC_WOC,   // write-only command register
    ACC_NONE   // unmapped
  } acc_e;

endpackage

// File: rtl/regfile_addr_decode.sv
// regfile_addr_decode
//   Purely combinational address decoder. Maps a full-width address to an
//   access type and an index inside that region. The IRQ mask register is
//   reported as ACC_RW with index N_RW (one past the last config register).
//   Ports:
//     i_addr  in  ADDR_W  register address
//     o_acc   out acc_e   access type
//     o_idx   out IDX_W   index within the region
module regfile_addr_decode
  import regfile_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          N_RW      = DEF_N_RW,
  parameter int unsigned RW_BASE   = DEF_RW_BASE,
  parameter int          N_STAT    = DEF_N_STAT,
  parameter int unsigned STAT_BASE = DEF_STAT_BASE,
  parameter int unsigned EVT_ADDR  = DEF_EVT_ADDR,
  parameter int unsigned CMD_ADDR  = DEF_CMD_ADDR,
  parameter int          IDX_W     = 4
) (
  input  logic [ADDR_W-1:0] i_addr,
  output acc_e              o_acc,
  output logic [IDX_W-1:0]  o_idx
);

  // Compare in 32 bits so base+count can never wrap; every address bit
  // participates, so there is no aliasing.
  logic [31:0] w_addr;
  assign w_addr = 32'(i_addr);

  // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    o_acc = ACC_NONE;
    o_idx = '0;
    if (w_addr >= RW_BASE && w_addr < RW_BASE + 32'(N_RW)) begin
      o_acc = ACC_RW;
      o_idx = IDX_W'(w_addr - RW_BASE);
    end else if (w_addr >= STAT_BASE && w_addr < STAT_BASE + 32'(N_STAT)) begin
      o_acc = ACC_RO;
      o_idx = IDX_W'(w_addr - STAT_BASE);
    end else if (w_addr == EVT_ADDR) begin
      o_acc = ACC_W1C;
    end else if (w_addr == EVT_ADDR + 32'd1) begin
      o_acc = ACC_RW;
      o_idx = IDX_W'(N_RW);
    end else if (w_addr == CMD_ADDR) begin
      o_acc = ACC_WOC;
    end
  end

endmodule

// File: rtl/regfile_cfg_bank.sv
// regfile_cfg_bank
//   Memory-mapped configuration bank: N_RW read/write config registers,
//   N_STAT read-only status words, a sticky W1C event register with an IRQ
//   mask, and a write-only command register producing one-cycle pulses.
//   Ports:
//     clk, rst            clock; asynchronous active-high reset
//     wr_en, rd_en        write / read strobes
//     addr, write_data    register address, write data
//     read_data, rd_valid registered read data, valid for one cycle
//     addr_err            one-cycle pulse on unmapped access
//     cfg_q               flattened config registers (reg i at [i*DATA_W +: DATA_W])
//     status_in           status words (word i at [i*DATA_W +: DATA_W])
//     event_in            event set pulses
//     irq                 registered OR of (events & mask)
//     cmd_pulse           command pulses
module regfile_cfg_bank
  import regfile_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          N_RW      = DEF_N_RW,
  parameter int unsigned RW_BASE   = DEF_RW_BASE,
  parameter int          N_STAT    = DEF_N_STAT,
  parameter int unsigned STAT_BASE = DEF_STAT_BASE,
  parameter int unsigned EVT_ADDR  = DEF_EVT_ADDR,
  parameter int unsigned CMD_ADDR  = DEF_CMD_ADDR,
  parameter int          N_CMD     = DEF_N_CMD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        write_data,
  output logic [DATA_W-1:0]        read_data,
  output logic                     rd_valid,
  output logic                     addr_err,
  output logic [N_RW*DATA_W-1:0]   cfg_q,
  input  logic [N_STAT*DATA_W-1:0] status_in,
  input  logic [DATA_W-1:0]        event_in,
  output logic                     irq,
  output logic [N_CMD-1:0]         cmd_pulse
);

  // Index must cover config 0..N_RW-1, the mask slot N_RW, and status words.
  localparam int IDX_N = (N_RW + 1 > N_STAT) ? N_RW + 1 : N_STAT;
  localparam int IDX_W = (IDX_N > 1) ? $clog2(IDX_N) : 1;

  acc_e             w_acc;
  logic [IDX_W-1:0] w_idx;
  logic [DATA_W-1:0] w_rd_val;
  logic [DATA_W-1:0] w_evt_clr;
  logic              w_wr_rw;

  logic [DATA_W-1:0] r_cfg [N_RW];
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_evt;
  logic [DATA_W-1:0] r_read_data;
  logic              r_rd_valid;
  logic              r_addr_err;
  logic              r_irq;
  logic [N_CMD-1:0]  r_cmd_pulse;

  regfile_addr_decode #(
    .ADDR_W    (ADDR_W),
    .N_RW      (N_RW),
    .RW_BASE   (RW_BASE),
    .N_STAT    (N_STAT),
    .STAT_BASE (STAT_BASE),
    .EVT_ADDR  (EVT_ADDR),
    .CMD_ADDR  (CMD_ADDR),
    .IDX_W     (IDX_W)
  ) u_decode (
    .i_addr (addr),
    .o_acc  (w_acc),
    .o_idx  (w_idx)
  );

  assign w_wr_rw   = wr_en && (w_acc == ACC_RW);
  assign w_evt_clr = (wr_en && (w_acc == ACC_W1C)) ? write_data : '0;

  // Read mux works on pre-write state, so a same-cycle read/write returns
  // the old value. Command and unmapped addresses read as zero.
  always_comb begin
    w_rd_val = '0;
    case (w_acc)
      ACC_RW: begin
        for (int i = 0; i < N_RW; i++)
          if (w_idx == IDX_W'(i)) w_rd_val = r_cfg[i];
        if (w_idx == IDX_W'(N_RW)) w_rd_val = r_mask;
      end
      ACC_RO: begin
        for (int i = 0; i < N_STAT; i++)
          if (w_idx == IDX_W'(i)) w_rd_val = status_in[i*DATA_W +: DATA_W];
      end
      ACC_W1C: w_rd_val = r_evt;
      default: w_rd_val = '0;
    endcase
  end

  // NOTE: the config array is reset explicitly; its contents are visible on cfg_q and must be 0 in reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_RW; i++) r_cfg[i] <= '0;
      r_mask <= '0;
    end else if (w_wr_rw) begin
      for (int i = 0; i < N_RW; i++)
        if (w_idx == IDX_W'(i)) r_cfg[i] <= write_data;
      if (w_idx == IDX_W'(N_RW)) r_mask <= write_data;
    end
  end

  // Set after clear: a coincident event_in bit survives its W1C write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt <= '0;
      r_irq <= 1'b0;
    end else begin
      r_evt <= (r_evt & ~w_evt_clr) | event_in;
      r_irq <= |(r_evt & r_mask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data <= '0;
      r_rd_valid  <= 1'b0;
      r_addr_err  <= 1'b0;
      r_cmd_pulse <= '0;
    end else begin
      if (rd_en) r_read_data <= w_rd_val;
      r_rd_valid  <= rd_en;
      r_addr_err  <= (wr_en || rd_en) && (w_acc == ACC_NONE);
      r_cmd_pulse <= (wr_en && (w_acc == ACC_WOC)) ? write_data[N_CMD-1:0] : '0;
    end
  end

  for (genvar g = 0; g < N_RW; g++) begin : g_cfg_q
    assign cfg_q[g*DATA_W +: DATA_W] = r_cfg[g];
  end

  assign read_data = r_read_data;
  assign rd_valid  = r_rd_valid;
  assign addr_err  = r_addr_err;
  assign irq       = r_irq;
  assign cmd_pulse = r_cmd_pulse;

endmodule
